// File: rtl/mdio_pkg.sv
// Shared types and field constants for the Clause 22 MDIO frame engine.
package mdio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFrame,
    StDone
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  // Bits after the preamble: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16).
  localparam int unsigned MDIO_FRAME_BITS = 32;
  // Offsets of the first TA bit and first DATA bit within those 32 bits.
  localparam int unsigned MDIO_TA_OFFSET   = 14;
  localparam int unsigned MDIO_DATA_OFFSET = 16;

  // Builds the ST..DATA word, MSB sent first. On reads the TA and DATA slots
  // are released, so they carry zeros that are never enabled onto the line.
  function automatic logic [MDIO_FRAME_BITS-1:0] mdio_frame_word(
    input logic       write,
    input logic [4:0] phy_addr,
    input logic [4:0] reg_addr,
    input logic [15:0] wdata
  );
    logic [1:0]  op;
    logic [1:0]  ta;
    logic [15:0] data;
    op   = write ? MDIO_OP_WRITE : MDIO_OP_READ;
    ta   = write ? MDIO_TA_WRITE : 2'b00;
    data = write ? wdata : 16'h0000;
    return {MDIO_ST, op, phy_addr, reg_addr, ta, data};
  endfunction

endpackage

// File: rtl/mdio_bit_timer.sv
// MDC divider: one bit period per CLK_DIV cycles, MDC low for the first half
// (floor) and high for the rest. Counter is held at zero whenever disabled.
module mdio_bit_timer
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic mdc,
  output logic bit_start,
  output logic sample
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CntHalf = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next counter value: wraps at CLK_DIV-1, forced to zero when disabled.
  always_comb begin
    cnt_d = '0;
    if (enable) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter and registered MDC, derived from the cycle index being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mdc   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc   <= (cnt_d >= CntHalf);
    end
  end

  // bit_start: the coming edge begins a new bit period (current one is ending).
  assign bit_start = enable && (cnt_q == CntLast);
  // sample: current cycle is the first MDC-high cycle of the bit.
  assign sample    = enable && (cnt_q == CntHalf);

endmodule

// File: rtl/mdio_frame_engine.sv
// Clause 22 MDIO frame engine: one command in, one 32+PREAMBLE_LEN bit frame
// out on MDC/MDIO, one response strobe back with captured read data.
module mdio_frame_engine
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 125,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_tx_en,
  output logic        mdio_tx_data,
  input  logic        mdio_rx_data
);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("mdio_frame_engine: CLK_DIV must be at least 4");
  end

  localparam int unsigned TotalBits = PREAMBLE_LEN + MDIO_FRAME_BITS;
  localparam int unsigned BW        = $clog2(TotalBits + 1);

  localparam logic [BW-1:0] BitLast   = BW'(TotalBits - 1);
  localparam logic [BW-1:0] PreLen    = BW'(PREAMBLE_LEN);
  localparam logic [BW-1:0] TaFirst   = BW'(PREAMBLE_LEN + MDIO_TA_OFFSET);
  localparam logic [BW-1:0] DataFirst = BW'(PREAMBLE_LEN + MDIO_DATA_OFFSET);

  mdio_state_e                state_q;
  logic                       ready_q;
  logic                       busy_q;
  logic                       tx_en_q;
  logic                       tx_data_q;
  logic                       rsp_valid_q;
  logic [15:0]                rsp_rdata_q;
  logic                       write_q;
  logic [BW-1:0]              bit_cnt_q;
  logic [MDIO_FRAME_BITS-1:0] sreg_q;
  logic [15:0]                rx_sh_q;

  logic frame_active;
  logic bit_start;
  logic sample;

  // Values for the bit about to be driven (bit 0 on accept, else bit_cnt+1).
  logic [BW-1:0]              emit_idx;
  logic [MDIO_FRAME_BITS-1:0] emit_src;
  logic                       emit_write;
  logic                       emit_pre;
  logic                       emit_data;
  logic                       emit_en;
  logic [MDIO_FRAME_BITS-1:0] emit_sreg;

  assign frame_active = (state_q == StFrame);

  mdio_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (frame_active),
    .mdc       (mdc),
    .bit_start (bit_start),
    .sample    (sample)
  );

  // Select the next outgoing bit: preamble ones, then the shift register MSB.
  always_comb begin
    emit_idx   = bit_cnt_q + 1'b1;
    emit_src   = sreg_q;
    emit_write = write_q;
    if (state_q == StIdle) begin
      emit_idx   = '0;
      emit_src   = mdio_frame_word(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
      emit_write = cmd_write;
    end
    emit_pre  = (emit_idx < PreLen);
    emit_data = emit_pre ? 1'b1 : emit_src[MDIO_FRAME_BITS-1];
    emit_sreg = emit_pre ? emit_src : {emit_src[MDIO_FRAME_BITS-2:0], 1'b0};
    // Reads release the line from the first TA bit to the end of the frame.
    emit_en   = emit_write || (emit_idx < TaFirst);
  end

  // Frame FSM with all externally visible outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      write_q     <= 1'b0;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      rx_sh_q     <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && ready_q) begin
            state_q   <= StFrame;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            write_q   <= cmd_write;
            bit_cnt_q <= '0;
            rx_sh_q   <= 16'h0000;
            sreg_q    <= emit_sreg;
            tx_data_q <= emit_data;
            tx_en_q   <= emit_en;
          end
        end
        StFrame: begin
          // TA samples are skipped; only DATA bits enter the read shifter.
          if (sample && !write_q && (bit_cnt_q >= DataFirst)) begin
            rx_sh_q <= {rx_sh_q[14:0], mdio_rx_data};
          end
          if (bit_start) begin
            if (bit_cnt_q == BitLast) begin
              state_q     <= StDone;
              busy_q      <= 1'b0;
              tx_en_q     <= 1'b0;
              tx_data_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= write_q ? 16'h0000 : rx_sh_q;
            end else begin
              bit_cnt_q <= emit_idx;
              sreg_q    <= emit_sreg;
              tx_data_q <= emit_data;
              tx_en_q   <= emit_en;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Ready is masked while reset is held so nothing is accepted during reset.
  assign cmd_ready    = ready_q & ~rst;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign mdio_tx_en   = tx_en_q;
  assign mdio_tx_data = tx_data_q;

endmodule
